// File: rtl/muldiv_sched_pkg.sv
// Shared MD opcode encodings, scheduler states and default latencies for the
// multiply/divide scheduler and its arithmetic core.
package muldiv_sched_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sched_arith.sv
// Combinational MD arithmetic: 64-bit products and truncating division with
// remainder, producing the pending HI/LO pair and a divide-by-zero flag.
module md_arith
  import muldiv_sched_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div0_o
);

  logic [63:0] prod;
  logic        sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  // Low 64 bits of the extended operands' product equal the signed product.
  always_comb begin
    if (op_i == MD_MULT)
      prod = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    else
      prod = {32'b0, a_i} * {32'b0, b_i};
  end

  // Magnitude division avoids the INT_MIN / -1 overflow of native signed divide.
  assign sgn    = (op_i == MD_DIV);
  assign a_neg  = sgn & a_i[31];
  assign b_neg  = sgn & b_i[31];
  assign div0_o = (b_i == '0);
  assign a_mag  = a_neg ? (~a_i + 32'd1) : a_i;
  assign b_mag  = div0_o ? 32'd1 : (b_neg ? (~b_i + 32'd1) : b_i);
  assign q_mag  = a_mag / b_mag;
  assign r_mag  = a_mag % b_mag;
  assign quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (is_mul(op_i)) begin
      hi_o = prod[63:32];
      lo_o = prod[31:0];
    end else if (is_div(op_i)) begin
      hi_o = rem;
      lo_o = quo;
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// Multiply/divide scheduler: owns HI/LO, holds the unit busy for a fixed
// latency per operation, and raises stall requests while occupied.
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_i,
  input  logic        md_start_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        hl_sel_i,
  input  logic        md_in_d_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic [31:0] hl_o
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        hi_nx_q, hi_nx_d, lo_nx_q, lo_nx_d;
  logic               wr_q, wr_d;
  logic [31:0]        ar_hi, ar_lo;
  logic               ar_div0;
  logic               long_op;

  md_arith u_arith (
    .op_i   (md_op_i),
    .a_i    (rs_i),
    .b_i    (rt_i),
    .hi_o   (ar_hi),
    .lo_o   (ar_lo),
    .div0_o (ar_div0)
  );

  assign long_op = is_mul(md_op_i) | is_div(md_op_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_nx_d = hi_nx_q;
    lo_nx_d = lo_nx_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start_i) begin
          if (long_op) begin
            state_d = ST_BUSY;
            cnt_d   = is_div(md_op_i) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
            hi_nx_d = ar_hi;
            lo_nx_d = ar_lo;
            wr_d    = ~ar_div0;
          end else if (md_op_i == MD_MTHI) begin
            hi_d = rs_i;
          end else if (md_op_i == MD_MTLO) begin
            lo_d = rs_i;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (wr_q) begin
            hi_d = hi_nx_q;
            lo_d = lo_nx_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_nx_q <= '0;
      lo_nx_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_nx_q <= hi_nx_d;
      lo_nx_q <= lo_nx_d;
      wr_q    <= wr_d;
    end
  end

  assign busy_o  = (state_q == ST_BUSY);
  assign stall_o = md_in_d_i & (busy_o | (md_start_i & long_op));
  assign hl_o    = hl_sel_i ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: latency, stall window, arithmetic results,
// MTHI/MTLO, divide-by-zero and mid-operation reset.
module tb_muldiv_sched;
  import muldiv_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic        md_start;
  logic [31:0] rs, rt;
  logic        hl_sel;
  logic        md_in_d;
  logic        busy, stall;
  logic [31:0] hl;

  int checks = 0;
  int errors = 0;

  muldiv_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .md_op_i    (md_op),
    .md_start_i (md_start),
    .rs_i       (rs),
    .rt_i       (rt),
    .hl_sel_i   (hl_sel),
    .md_in_d_i  (md_in_d),
    .busy_o     (busy),
    .stall_o    (stall),
    .hl_o       (hl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op    = op;
    rs       = a;
    rt       = b;
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    md_op    = MD_NONE;
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    hl_sel = 1'b1;
    #1;
    chk({tag, "_hi"}, hl, exp_hi);
    hl_sel = 1'b0;
    #1;
    chk({tag, "_lo"}, hl, exp_lo);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    md_op    = MD_NONE;
    md_start = 1'b0;
    rs       = '0;
    rt       = '0;
    hl_sel   = 1'b0;
    md_in_d  = 1'b0;
    #3;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk_hilo("rst", 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Unqualified opcode must not start anything
    md_op = MD_MULT; rs = 32'd9; rt = 32'd9;
    tick();
    md_op = MD_NONE;
    #1;
    chk("nostart_busy", {31'b0, busy}, 32'd0);

    // 1: MULT -2 * 3
    start_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_old_lo", hl, 32'h0);
    count_busy(n);
    chk("mult_lat", n, 32'd5);
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // 2: DIVU 100/7 with mflo in D -> 11 stall cycles
    md_in_d = 1'b1;
    md_op = MD_DIVU; rs = 32'd100; rt = 32'd7; md_start = 1'b1;
    #1;
    n = 0;
    if (stall) n++;
    tick();
    md_start = 1'b0;
    md_op = MD_NONE;
    #1;
    while (stall && n < 40) begin
      n++;
      tick();
    end
    chk("divu_stall", n, 32'd11);
    md_in_d = 1'b0;
    chk_hilo("divu", 32'd2, 32'd14);

    // 3: DIV -7 / 2
    start_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    chk("div_lat", n, 32'd10);
    chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Overflow corner: INT_MIN / -1
    start_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    chk_hilo("divovf", 32'h0, 32'h8000_0000);

    // MULTU 0xFFFFFFFF * 2
    start_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    chk("multu_lat", n, 32'd5);
    chk_hilo("multu", 32'h1, 32'hFFFF_FFFE);

    // 4: MTHI, with MD instr in D: no stall, no busy
    md_in_d = 1'b1;
    md_op = MD_MTHI; rs = 32'h1234_5678; md_start = 1'b1;
    #1;
    chk("mthi_stall", {31'b0, stall}, 32'd0);
    tick();
    md_start = 1'b0;
    md_op = MD_NONE;
    md_in_d = 1'b0;
    #1;
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk_hilo("mthi", 32'h1234_5678, 32'hFFFF_FFFE);

    // 5: MTLO then DIV by zero
    start_op(MD_MTLO, 32'hA5A5_A5A5, 32'd0);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    chk_hilo("mtlo", 32'h1234_5678, 32'hA5A5_A5A5);
    start_op(MD_DIV, 32'd5, 32'd0);
    count_busy(n);
    chk("div0_lat", n, 32'd10);
    chk_hilo("div0", 32'h1234_5678, 32'hA5A5_A5A5);

    // 6: reset in cycle 3 of MULTU
    start_op(MD_MULTU, 32'd3, 32'd4);
    tick();
    tick();
    md_in_d = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    chk_hilo("rst_mid", 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    md_in_d = 1'b0;
    repeat (8) tick();
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk_hilo("post_rst", 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
